// File: rtl/operand_fetch.sv
// Operand fetch: forms rp*stride+cp as a data-memory address and performs
// one read or write per start request, reporting completion with done.
module operand_fetch #(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int READ_LAT = 2
) (
    input  logic          Clk,
    input  logic          RST,
    input  logic          stride_we,
    input  logic [DW-1:0] BusOut,
    input  logic [AW-1:0] rp,
    input  logic [AW-1:0] cp,
    input  logic          start,
    input  logic          wr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] data_out,
    output logic          done,
    output logic          busy,
    output logic          ovf
);

    localparam int SW = 2 * AW + 1;
    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    cnt;
    logic [2:0]    cnt_nxt;
    logic          last_rd;
    logic          accept;
    logic [AW-1:0] stride;
    logic [AW-1:0] rp_q;
    logic [AW-1:0] cp_q;
    logic          wr_q;
    logic [SW-1:0] sum;

    assign accept = (state == S_IDLE) && start;
    assign sum    = SW'(rp_q) * SW'(stride) + SW'(cp_q);
    assign done   = (state == S_DONE);
    assign busy   = (state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // last_rd marks the final latency cycle, where read data is valid
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_rd   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CALC;
            end
            S_CALC: begin
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (wr_q) begin
                    state_nxt = S_DONE;
                end else if (LAT_M1 == 3'd0) begin
                    state_nxt = S_DONE;
                    last_rd   = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 3'd1;
                end
            end
            S_WAIT: begin
                if (cnt == LAT_M1) begin
                    state_nxt = S_DONE;
                    last_rd   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            stride    <= '0;
            rp_q      <= '0;
            cp_q      <= '0;
            wr_q      <= 1'b0;
            mem_addr  <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            data_out  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (stride_we) stride <= BusOut[AW-1:0];
            if (accept) begin
                rp_q      <= rp;
                cp_q      <= cp;
                wr_q      <= wr;
                mem_wdata <= BusOut;
            end
            // strobes are registered so they occupy exactly the ACCESS cycle
            if (state == S_CALC) begin
                mem_addr <= sum[AW-1:0];
                ovf      <= |sum[SW-1:AW];
                mem_ren  <= ~wr_q;
                mem_wen  <= wr_q;
            end else begin
                mem_ren <= 1'b0;
                mem_wen <= 1'b0;
            end
            if (last_rd) data_out <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed and random accesses checked cycle by
// cycle against a plain-arithmetic address model and a shadow memory.
module tb_operand_fetch;

    logic       Clk = 1'b0;
    logic       RST;
    logic       stride_we;
    logic [7:0] BusOut;
    logic [7:0] rp;
    logic [7:0] cp;
    logic       start;
    logic       wr;
    logic [7:0] mem_addr;
    logic       mem_ren;
    logic       mem_wen;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] data_out;
    logic       done;
    logic       busy;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_mem [256];
    int         stride_m;
    logic [7:0] dout_m;

    always #5 Clk = ~Clk;

    operand_fetch #(.DW(8), .AW(8), .READ_LAT(2)) dut (
        .Clk(Clk), .RST(RST), .stride_we(stride_we), .BusOut(BusOut),
        .rp(rp), .cp(cp), .start(start), .wr(wr),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .data_out(data_out), .done(done), .busy(busy), .ovf(ovf)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a * 8'd37) ^ 8'h5A;
    endfunction

    // data RAM with two-cycle read latency; bus shows poison when idle
    logic [7:0] mem [256];
    logic       fill;
    logic       rvalid;
    logic [7:0] rdata_q;

    always @(posedge Clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
        end else if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
        end
        rvalid <= mem_ren;
        if (mem_ren) rdata_q <= mem[mem_addr];
    end

    assign mem_rdata = rvalid ? rdata_q : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_stride(input logic [7:0] v);
        @(negedge Clk);
        stride_we = 1'b1;
        BusOut    = v;
        @(negedge Clk);
        stride_we = 1'b0;
        stride_m  = int'(v);
    endtask

    // One access from cycle 0 to the done cycle. noise drives start and
    // garbage operands while busy; nstride>=0 loads a stride during CALC.
    task automatic access(input logic [7:0] r, input logic [7:0] c,
                          input logic w, input logic [7:0] d,
                          input bit noise, input int nstride);
        int         s;
        logic [7:0] ea;
        logic       eo;
        s  = int'(r) * stride_m + int'(c);
        ea = 8'(s % 256);
        eo = (s > 255);
        @(negedge Clk);
        chk("c0_busy", busy, 0);
        chk("c0_done", done, 0);
        start  = 1'b1;
        rp     = r;
        cp     = c;
        wr     = w;
        BusOut = d;
        @(negedge Clk);
        start = noise;
        if (noise) begin
            rp     = 8'($urandom);
            cp     = 8'($urandom);
            wr     = ~w;
            BusOut = 8'($urandom);
        end
        if (nstride >= 0) begin
            stride_we = 1'b1;
            BusOut    = 8'(nstride);
        end
        chk("c1_busy", busy, 1);
        chk("c1_ren", mem_ren, 0);
        chk("c1_wen", mem_wen, 0);
        chk("c1_done", done, 0);
        @(negedge Clk);
        stride_we = 1'b0;
        if (nstride >= 0) stride_m = nstride;
        chk("c2_busy", busy, 1);
        chk("c2_addr", mem_addr, ea);
        chk("c2_ovf", ovf, eo);
        chk("c2_ren", mem_ren, !w);
        chk("c2_wen", mem_wen, w);
        chk("c2_done", done, 0);
        if (w) chk("c2_wdata", mem_wdata, d);
        if (w) begin
            @(negedge Clk);
            start = 1'b0;
            ref_mem[ea] = d;
            chk("wr_done", done, 1);
            chk("wr_busy", busy, 1);
            chk("wr_wen", mem_wen, 0);
            chk("wr_dout", data_out, dout_m);
        end else begin
            @(negedge Clk);
            chk("rd_c3_done", done, 0);
            chk("rd_c3_ren", mem_ren, 0);
            chk("rd_c3_busy", busy, 1);
            @(negedge Clk);
            start  = 1'b0;
            dout_m = ref_mem[ea];
            chk("rd_done", done, 1);
            chk("rd_busy", busy, 1);
            chk("rd_dout", data_out, dout_m);
            chk("rd_addr_hold", mem_addr, ea);
            chk("rd_ovf_hold", ovf, eo);
        end
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_ren"}, mem_ren, 0);
        chk({tag, "_wen"}, mem_wen, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        RST       = 1'b1;
        fill      = 1'b1;
        stride_we = 1'b0;
        BusOut    = '0;
        rp        = '0;
        cp        = '0;
        start     = 1'b0;
        wr        = 1'b0;
        stride_m  = 0;
        dout_m    = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        repeat (2) @(negedge Clk);
        reset_outputs("rst");
        RST  = 1'b0;
        fill = 1'b0;

        // zero stride gives address = cp
        access(8'h77, 8'hC3, 1'b0, 8'h00, 1'b0, -1);

        // basic read and write
        set_stride(8'd4);
        access(8'd2, 8'd3, 1'b0, 8'h00, 1'b0, -1);
        access(8'd1, 8'd1, 1'b1, 8'hA5, 1'b0, -1);
        access(8'd1, 8'd1, 1'b0, 8'h00, 1'b0, -1);

        // wrap and overflow flag
        set_stride(8'h20);
        access(8'h09, 8'h05, 1'b0, 8'h00, 1'b0, -1);
        access(8'h00, 8'h05, 1'b0, 8'h00, 1'b0, -1);
        access(8'hFF, 8'hFF, 1'b1, 8'h3C, 1'b0, -1);

        // start while busy ignored; stride load during CALC used next time
        access(8'h03, 8'h07, 1'b0, 8'h00, 1'b1, 9);
        access(8'h03, 8'h07, 1'b1, 8'h66, 1'b1, 5);
        access(8'h03, 8'h07, 1'b0, 8'h00, 1'b0, -1);

        // start together with RST stays idle
        @(negedge Clk);
        start = 1'b1;
        RST   = 1'b1;
        @(negedge Clk);
        start    = 1'b0;
        RST      = 1'b0;
        stride_m = 0;
        dout_m   = '0;
        reset_outputs("strst");
        @(negedge Clk);
        chk("strst_busy2", busy, 0);
        chk("strst_ren2", mem_ren, 0);

        // reset in the middle of a read aborts it
        set_stride(8'd6);
        @(negedge Clk);
        start = 1'b1;
        rp    = 8'd4;
        cp    = 8'd2;
        wr    = 1'b0;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        chk("mid_ren_before", mem_ren, 1);
        RST = 1'b1;
        @(negedge Clk);
        reset_outputs("mid1");
        @(negedge Clk);
        reset_outputs("mid2");
        RST      = 1'b0;
        stride_m = 0;
        dout_m   = '0;
        repeat (3) begin
            @(negedge Clk);
            chk("mid_nodone", done, 0);
            chk("mid_idle", busy, 0);
        end

        // back-to-back reads
        set_stride(8'($urandom));
        for (int k = 0; k < 8; k++)
            access(8'($urandom), 8'($urandom), 1'b0, 8'h00, 1'b0, -1);

        // random mix
        for (int k = 0; k < 24; k++) begin
            if (k % 6 == 0) set_stride(8'($urandom));
            access(8'($urandom), 8'($urandom), 1'($urandom),
                   8'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1);
        end

        @(negedge Clk);
        chk("end_idle", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
